// File: rtl/prog_mod_cntr.sv
// Programmable up/down modulo-M counter with load, one-shot halt, terminal-count
// pulse and a wrap counter. mod_q==0 selects a modulus of 2**W.
module prog_mod_cntr #(
  parameter int W       = 10,
  parameter int MOD_DEF = 10,
  parameter int CW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          up,
  input  logic          ld,
  input  logic [W-1:0]  ld_val,
  input  logic          mod_wr,
  input  logic [W-1:0]  mod_in,
  input  logic          oneshot,
  output logic [W-1:0]  cnt,
  output logic          tc,
  output logic          ld_err,
  output logic          halted,
  output logic [CW-1:0] wraps
);

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_HALT = 1'b1;
  localparam logic [W:0] ONE    = (W+1)'(1);

  logic [0:0]   state;
  logic [W-1:0] mod_q;
  logic [W:0]   m_full, m_last;
  logic         at_top, at_bot, step, wrap, ld_bad;
  logic [W-1:0] cnt_step;

  // Modulus held in W+1 bits so 2**W is representable.
  assign m_full = (mod_q == '0) ? {1'b1, {W{1'b0}}} : {1'b0, mod_q};
  assign m_last = m_full - ONE;

  assign at_top = ({1'b0, cnt} == m_last);
  assign at_bot = (cnt == '0);
  assign step   = (state == S_RUN) && en;
  assign wrap   = step && (up ? at_top : at_bot);
  assign ld_bad = ({1'b0, ld_val} >= m_full);

  always_comb begin
    cnt_step = cnt;
    if (up) cnt_step = at_top ? '0 : cnt + W'(1);
    else    cnt_step = at_bot ? m_last[W-1:0] : cnt - W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      mod_q  <= W'(MOD_DEF);
      tc     <= 1'b0;
      ld_err <= 1'b0;
      wraps  <= '0;
      state  <= S_RUN;
    end else begin
      tc     <= 1'b0;
      ld_err <= 1'b0;
      if (mod_wr) begin
        mod_q <= mod_in;
        cnt   <= '0;
        wraps <= '0;
        state <= S_RUN;
      end else if (ld) begin
        cnt    <= ld_bad ? '0 : ld_val;
        ld_err <= ld_bad;
        state  <= S_RUN;
      end else if (step) begin
        cnt <= cnt_step;
        if (wrap) begin
          tc    <= 1'b1;
          wraps <= wraps + CW'(1);
          if (oneshot) state <= S_HALT;
        end
      end
    end
  end

  assign halted = (state == S_HALT);

endmodule

// File: tb/tb_prog_mod_cntr.sv
// Bench for prog_mod_cntr: directed table, hand sequences and a randomized run,
// all checked through an expected-result queue.
module tb_prog_mod_cntr;
  logic       clk = 1'b0;
  logic       rst, en, up, ld, mod_wr, oneshot;
  logic [9:0] ld_val, mod_in;
  logic [9:0] cnt;
  logic       tc, ld_err, halted;
  logic [7:0] wraps;

  prog_mod_cntr #(.W(10), .MOD_DEF(10), .CW(8)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .ld(ld), .ld_val(ld_val),
    .mod_wr(mod_wr), .mod_in(mod_in), .oneshot(oneshot),
    .cnt(cnt), .tc(tc), .ld_err(ld_err), .halted(halted), .wraps(wraps)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt; bit tc; bit le; bit h; int wr;
  } exp_t;

  typedef struct {
    bit r, e, u, l; int lv; bit mw; int mi; bit os;
    int cnt; bit tc; bit le; bit h; int wr;
  } vec_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state
  int m_c, m_mq, m_wr;
  bit m_tc, m_le, m_h;

  task automatic model(input bit r, e, u, l, input int lv, input bit mw,
                       input int mi, input bit os);
    int m;
    m = (m_mq == 0) ? 1024 : m_mq;
    m_tc = 0;
    m_le = 0;
    if (r) begin
      m_c = 0; m_mq = 10; m_h = 0; m_wr = 0;
    end else if (mw) begin
      m_mq = mi; m_c = 0; m_wr = 0; m_h = 0;
    end else if (l) begin
      m_h = 0;
      if (lv < m) m_c = lv;
      else begin m_c = 0; m_le = 1; end
    end else if (!m_h && e) begin
      if (u) begin
        if (m_c == m - 1) begin m_c = 0; m_tc = 1; end
        else m_c = m_c + 1;
      end else begin
        if (m_c == 0) begin m_c = m - 1; m_tc = 1; end
        else m_c = m_c - 1;
      end
      if (m_tc) begin
        m_wr = (m_wr + 1) % 256;
        if (os) m_h = 1;
      end
    end
  endtask

  task automatic drive(input string tag, input bit r, e, u, l, input int lv,
                       input bit mw, input int mi, input bit os,
                       input bit use_vec, input exp_t ve);
    exp_t x, got;
    rst = r; en = e; up = u; ld = l; ld_val = 10'(lv);
    mod_wr = mw; mod_in = 10'(mi); oneshot = os;
    model(r, e, u, l, lv, mw, mi, os);
    x = use_vec ? ve : '{m_c, m_tc, m_le, m_h, m_wr};
    sbq.push_back(x);
    @(posedge clk);
    #1;
    x = sbq.pop_front();
    got = '{int'(cnt), tc, ld_err, halted, int'(wraps)};
    checks++;
    if (got != x) begin
      errors++;
      $display("FAIL %s: got cnt=%0d tc=%0b ld_err=%0b halted=%0b wraps=%0d, want cnt=%0d tc=%0b ld_err=%0b halted=%0b wraps=%0d",
               tag, got.cnt, got.tc, got.le, got.h, got.wr, x.cnt, x.tc, x.le, x.h, x.wr);
    end
  endtask

  task automatic run(input string tag, input int n, input bit e, u, input bit os);
    exp_t nul;
    nul = '{0, 0, 0, 0, 0};
    for (int i = 0; i < n; i++) drive(tag, 0, e, u, 0, 0, 0, 0, os, 0, nul);
  endtask

  task automatic ctl(input string tag, input bit r, l, input int lv,
                     input bit mw, input int mi);
    exp_t nul;
    nul = '{0, 0, 0, 0, 0};
    drive(tag, r, 0, 1, l, lv, mw, mi, 0, 0, nul);
  endtask

  vec_t tbl[27];

  initial begin
    exp_t ve;
    //           r e u l lv mw mi os   cnt tc le h wr
    tbl[0]  = '{1,0,1,0, 0,0, 0,0,   0,0,0,0,0};
    tbl[1]  = '{0,1,1,1, 5,0, 0,0,   5,0,0,0,0};
    tbl[2]  = '{0,1,1,0, 0,0, 0,0,   6,0,0,0,0};
    tbl[3]  = '{0,1,1,1,12,0, 0,0,   0,0,1,0,0};
    tbl[4]  = '{0,0,1,0, 0,0, 0,0,   0,0,0,0,0};
    tbl[5]  = '{0,1,1,1, 3,1, 4,0,   0,0,0,0,0};
    tbl[6]  = '{0,1,1,0, 0,0, 0,1,   1,0,0,0,0};
    tbl[7]  = '{0,1,1,0, 0,0, 0,1,   2,0,0,0,0};
    tbl[8]  = '{0,1,1,0, 0,0, 0,1,   3,0,0,0,0};
    tbl[9]  = '{0,1,1,0, 0,0, 0,1,   0,1,0,1,1};
    tbl[10] = '{0,1,1,0, 0,0, 0,0,   0,0,0,1,1};
    tbl[11] = '{0,1,1,1, 2,0, 0,0,   2,0,0,0,1};
    tbl[12] = '{0,1,1,0, 0,0, 0,1,   3,0,0,0,1};
    tbl[13] = '{0,1,1,0, 0,0, 0,1,   0,1,0,1,2};
    tbl[14] = '{0,1,0,0, 0,0, 0,0,   0,0,0,1,2};
    tbl[15] = '{0,0,1,0, 0,1, 1,0,   0,0,0,0,0};
    tbl[16] = '{0,1,1,0, 0,0, 0,0,   0,1,0,0,1};
    tbl[17] = '{0,1,0,0, 0,0, 0,0,   0,1,0,0,2};
    tbl[18] = '{0,0,1,0, 0,0, 0,0,   0,0,0,0,2};
    tbl[19] = '{0,0,1,0, 0,1,10,0,   0,0,0,0,0};
    tbl[20] = '{0,1,0,0, 0,0, 0,0,   9,1,0,0,1};
    tbl[21] = '{0,1,0,0, 0,0, 0,0,   8,0,0,0,1};
    tbl[22] = '{0,1,1,0, 0,0, 0,0,   9,0,0,0,1};
    tbl[23] = '{0,1,1,0, 0,0, 0,0,   0,1,0,0,2};
    tbl[24] = '{0,0,1,1, 9,0, 0,0,   9,0,0,0,2};
    tbl[25] = '{0,0,1,1,10,0, 0,0,   0,0,1,0,2};
    tbl[26] = '{1,1,1,1, 3,1, 5,1,   0,0,0,0,0};

    rst = 1; en = 0; up = 1; ld = 0; ld_val = 0; mod_wr = 0; mod_in = 0; oneshot = 0;

    // reset then plain mod-10 up count
    for (int i = 0; i < 3; i++) ctl("reset", 1, 0, 0, 0, 0);
    run("up10", 40, 1, 1, 0);
    checks++;
    if (wraps != 8'd4 || cnt != 10'd0) begin
      errors++;
      $display("FAIL wraps40: got wraps=%0d cnt=%0d, want wraps=4 cnt=0", wraps, cnt);
    end

    run("down10", 11, 1, 0, 0);

    // modulus rewrite mid-count, then 2**W and M=1
    run("to8", 8, 1, 1, 0);
    ctl("modwr7", 0, 0, 0, 1, 7);
    run("mod7", 14, 1, 1, 0);
    ctl("modwr0", 0, 0, 0, 1, 0);
    run("mod1024", 1025, 1, 1, 0);
    run("mod1024dn", 3, 1, 0, 0);
    ctl("modwr1", 0, 0, 0, 1, 1);
    run("mod1", 5, 1, 1, 0);

    // directed table: load, error, priority, one-shot, halt, reset override
    for (int i = 0; i < 27; i++) begin
      ve = '{tbl[i].cnt, tbl[i].tc, tbl[i].le, tbl[i].h, tbl[i].wr};
      drive($sformatf("tbl%0d", i), tbl[i].r, tbl[i].e, tbl[i].u, tbl[i].l,
            tbl[i].lv, tbl[i].mw, tbl[i].mi, tbl[i].os, 1, ve);
    end

    // randomized en/up with sparse loads and one mid-run reset
    for (int i = 0; i < 1000; i++) begin
      exp_t nul;
      bit   r, l;
      nul = '{0, 0, 0, 0, 0};
      r = (i == 500);
      l = ($urandom_range(0, 31) == 0);
      drive("rand", r, 1'($urandom), 1'($urandom), l, $urandom_range(0, 12),
            0, 0, 0, 0, nul);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
